// File: rtl/minmax_stream_sched.sv
// Streaming min/max finder: packs serial samples into NI-lane windows, reduces each
// window through a combinational comparison tree and merges into a running frame result.
//
// state  | meaning
// IDLE   | waiting for start with a non-zero frame_len
// FILL   | accepting samples into the window buffer
// REDUCE | tree output merged into the running result (one cycle)
// OUT    | result presented until the consumer accepts it
module minmax_stream_sched #(
    parameter int W    = 5,
    parameter int NI   = 7,
    parameter int IDXW = $clog2(NI),
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] frame_len,
    input  logic            us_sel,
    input  logic            min_max_sel,
    input  logic            s_valid,
    input  logic [W-1:0]    s_data,
    output logic            s_ready,
    output logic            busy,
    output logic            m_valid,
    output logic [W-1:0]    m_result,
    output logic [CNTW-1:0] m_index,
    input  logic            m_ready
);

    localparam int LCW = $clog2(NI + 1);

    typedef enum logic [1:0] {IDLE, FILL, REDUCE, OUT} state_t;

    state_t          state;
    logic [CNTW-1:0] cfg_len;
    logic            cfg_signed;
    logic            cfg_max;
    logic [LCW-1:0]  lane_cnt;
    logic [CNTW-1:0] sample_cnt;
    logic [CNTW-1:0] win_base;
    logic [W-1:0]    win_buf [NI];
    logic            first_win;

    logic [W-1:0]    pad_val;
    logic [W-1:0]    tv [NI];
    logic [IDXW-1:0] ti [NI];
    logic [W-1:0]    tree_val;
    logic [IDXW-1:0] tree_idx;
    int              n;

    // Signed order is mapped onto unsigned order by flipping the sign bit.
    function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sgn, input logic mx);
        logic [W-1:0] ak;
        logic [W-1:0] bk;
        ak = a ^ {sgn, {(W-1){1'b0}}};
        bk = b ^ {sgn, {(W-1){1'b0}}};
        return mx ? (ak > bk) : (ak < bk);
    endfunction

    always_comb begin
        if (cfg_max)
            pad_val = cfg_signed ? {1'b1, {(W-1){1'b0}}} : {W{1'b0}};
        else
            pad_val = cfg_signed ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};
    end

    // Pairwise tree; the left operand always holds lower lanes, so it wins ties.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            tv[i] = (LCW'(i) >= lane_cnt) ? pad_val : win_buf[i];
            ti[i] = IDXW'(i);
        end
        n = NI;
        for (int lvl = 0; lvl < $clog2(NI); lvl++) begin
            for (int i = 0; i < NI / 2; i++) begin
                if (2 * i + 1 < n) begin
                    if (better(tv[2*i+1], tv[2*i], cfg_signed, cfg_max)) begin
                        tv[i] = tv[2*i+1];
                        ti[i] = ti[2*i+1];
                    end else begin
                        tv[i] = tv[2*i];
                        ti[i] = ti[2*i];
                    end
                end
            end
            if (n % 2 == 1) begin
                tv[n/2] = tv[n-1];
                ti[n/2] = ti[n-1];
            end
            n = (n + 1) / 2;
        end
        tree_val = tv[0];
        tree_idx = ti[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            m_valid    <= 1'b0;
            m_result   <= '0;
            m_index    <= '0;
            cfg_len    <= '0;
            cfg_signed <= 1'b0;
            cfg_max    <= 1'b0;
            lane_cnt   <= '0;
            sample_cnt <= '0;
            win_base   <= '0;
            first_win  <= 1'b0;
            for (int i = 0; i < NI; i++) win_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (frame_len != '0)) begin
                        cfg_len    <= frame_len;
                        cfg_signed <= us_sel;
                        cfg_max    <= min_max_sel;
                        lane_cnt   <= '0;
                        sample_cnt <= '0;
                        win_base   <= '0;
                        first_win  <= 1'b1;
                        state      <= FILL;
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                FILL: begin
                    if (s_valid && s_ready) begin
                        win_buf[lane_cnt[IDXW-1:0]] <= s_data;
                        lane_cnt   <= lane_cnt + 1'b1;
                        sample_cnt <= sample_cnt + 1'b1;
                        if ((lane_cnt == LCW'(NI - 1)) || (sample_cnt == cfg_len - 1'b1)) begin
                            state   <= REDUCE;
                            s_ready <= 1'b0;
                        end
                    end
                end
                REDUCE: begin
                    if (first_win || better(tree_val, m_result, cfg_signed, cfg_max)) begin
                        m_result <= tree_val;
                        m_index  <= win_base + CNTW'(tree_idx);
                    end
                    first_win <= 1'b0;
                    if (sample_cnt == cfg_len) begin
                        state   <= OUT;
                        m_valid <= 1'b1;
                    end else begin
                        win_base <= win_base + CNTW'(NI);
                        lane_cnt <= '0;
                        state    <= FILL;
                        s_ready  <= 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_stream_sched.sv
// Directed bench for minmax_stream_sched: hand-computed frames covering compare modes,
// padding, ties, latency, output backpressure and reset.
module tb_minmax_stream_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] frame_len;
    logic        us_sel;
    logic        min_max_sel;
    logic        s_valid;
    logic [4:0]  s_data;
    logic        s_ready;
    logic        busy;
    logic        m_valid;
    logic [4:0]  m_result;
    logic [15:0] m_index;
    logic        m_ready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    minmax_stream_sched dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .us_sel(us_sel), .min_max_sel(min_max_sel),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .busy(busy), .m_valid(m_valid), .m_result(m_result),
        .m_index(m_index), .m_ready(m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len, input logic sg, input logic mx);
        start = 1'b1; frame_len = len; us_sel = sg; min_max_sel = mx;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] d);
        int w;
        w = 0;
        s_valid = 1'b1; s_data = d;
        while (!s_ready && w < 100) begin step(); w++; end
        if (!s_ready) chk("s_ready_timeout", s_ready, 1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int w;
        w = 0;
        while (!m_valid && w < 200) begin step(); w++; end
        chk({tag, "_mvalid"}, m_valid, 1);
    endtask

    task automatic take();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("take_mvalid_low", m_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = '0; us_sel = 1'b0; min_max_sel = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_result", m_result, 0);
        chk("rst_m_index", m_index, 0);

        // unsigned min over two windows, ties at 6 and 9 rejected
        do_start(16'd10, 1'b0, 1'b0);
        chk("umin_busy", busy, 1);
        send(5'd12); send(5'd7); send(5'd25); send(5'd7); send(5'd3);
        send(5'd19); send(5'd3); send(5'd8); send(5'd31); send(5'd3);
        wait_out("umin");
        chk("umin_result", m_result, 3);
        chk("umin_index", m_index, 4);
        take();

        // signed max then unsigned max on the same samples
        do_start(16'd3, 1'b1, 1'b1);
        send(5'b01111); send(5'b10000); send(5'b00001);
        wait_out("smax");
        chk("smax_result", m_result, 5'b01111);
        chk("smax_index", m_index, 0);
        take();
        do_start(16'd3, 1'b0, 1'b1);
        send(5'b01111); send(5'b10000); send(5'b00001);
        wait_out("umax");
        chk("umax_result", m_result, 5'b10000);
        chk("umax_index", m_index, 1);
        take();

        // signed min, second window holds one real sample and six pads
        do_start(16'd8, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) send(5'd0);
        send(5'b10000);
        wait_out("smin_pad");
        chk("smin_pad_result", m_result, 5'b10000);
        chk("smin_pad_index", m_index, 7);
        take();

        do_start(16'd1, 1'b0, 1'b0);
        send(5'd9);
        wait_out("len1");
        chk("len1_result", m_result, 9);
        chk("len1_index", m_index, 0);
        take();

        // exact window with s_valid gaps; check REDUCE bubble and latency
        do_start(16'd7, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            s_valid = 1'b1; s_data = 5'(k);
            chk("exact_s_ready", s_ready, 1);
            step();
            s_valid = 1'b0;
            if (k < 7) step();
        end
        chk("exact_reduce_s_ready", s_ready, 0);
        chk("exact_reduce_m_valid", m_valid, 0);
        step();
        chk("exact_m_valid", m_valid, 1);
        chk("exact_result", m_result, 7);
        chk("exact_index", m_index, 6);

        // backpressure with a start pulse during OUT
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin start = 1'b1; frame_len = 16'd4; end
            step();
            start = 1'b0;
            chk("bp_m_valid", m_valid, 1);
            chk("bp_result", m_result, 7);
            chk("bp_index", m_index, 6);
            chk("bp_busy", busy, 1);
        end
        take();
        chk("bp_idle_busy", busy, 0);
        do_start(16'd3, 1'b0, 1'b0);
        chk("next_start_busy", busy, 1);
        send(5'd4); send(5'd2); send(5'd6);
        wait_out("next");
        chk("next_result", m_result, 2);
        chk("next_index", m_index, 1);
        take();

        // reset mid-frame
        do_start(16'd10, 1'b0, 1'b1);
        send(5'd1); send(5'd2); send(5'd3); send(5'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_s_ready", s_ready, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_m_result", m_result, 0);
        chk("mrst_m_index", m_index, 0);
        step(); step();
        chk("mrst_no_out", m_valid, 0);

        do_start(16'd0, 1'b0, 1'b0);
        chk("zero_len_busy", busy, 0);
        chk("zero_len_s_ready", s_ready, 0);

        do_start(16'd3, 1'b1, 1'b1);
        send(5'd3); send(5'b11111); send(5'd3);
        wait_out("post_rst");
        chk("post_rst_result", m_result, 3);
        chk("post_rst_index", m_index, 0);
        take();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/minmax_stream_sched.md
Name: minmax_stream_sched

Overview:
- Streaming controller that computes the min or max of a frame of W-bit samples, and the position of that sample within the frame.
- Samples arrive serially on a valid/ready stream and are packed into NI-lane windows.
- Each window is reduced by an internal NI-input min/max comparison tree (lowest lane wins ties), then merged into a running frame result.
- Sits between a sample source and a consumer; the result is presented on a valid/ready output.

Parameters:
- W, 5, sample width.
- NI, 7, window lanes (tree inputs); NI>=2.
- IDXW, $clog2(NI), lane index width.
- CNTW, 16, frame length / global index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  frame start pulse; samples frame_len, us_sel, min_max_sel.
- frame_len  in  CNTW  number of samples in frame.
- us_sel  in  1  0=unsigned, 1=signed compare.
- min_max_sel  in  1  0=min, 1=max.
- s_valid  in  1  sample valid.
- s_data  in  W  sample.
- s_ready  out  1  sample accepted when s_valid&s_ready.
- busy  out  1  high in any state except IDLE.
- m_valid  out  1  frame result valid.
- m_result  out  W  selected sample value.
- m_index  out  CNTW  frame position of the selected sample (0-based).
- m_ready  in  1  consumer accept.

Behaviour:
- Reset: state=IDLE. s_ready, busy, m_valid = 0. m_result, m_index, lane counter, sample counter, window base, window buffer = 0.
- Reset mid-frame abandons the frame; no output is produced.
- States: IDLE, FILL, REDUCE, OUT.
- IDLE:
  - start with frame_len!=0 latches cfg (frame_len, us_sel, min_max_sel) and clears counters, then goes to FILL.
  - start with frame_len==0 is ignored.
  - start in any other state is ignored.
- FILL:
  - s_ready=1; on each handshake, s_data is written to lane[lane_cnt] and the counters increment.
  - Go to REDUCE on the handshake that fills lane NI-1, or on the handshake that accepts sample frame_len-1.
  - s_valid gaps stall FILL indefinitely.
- REDUCE (1 cycle):
  - s_ready=0.
  - Lanes not written in this window are padded with the identity value:
    - unsigned min: all-ones.
    - unsigned max: 0.
    - signed min: 0 followed by all-ones (most positive).
    - signed max: 1 followed by zeros (most negative).
  - Tree output is (val, lane); lane is the lowest lane among equals, so a pad never beats an equal real sample at a lower lane.
  - Candidate global index = window_base + lane.
  - Merge: the first window loads unconditionally. Later windows replace the running result only if strictly better (min: <, max: >); ties keep the earlier index.
  - Then, if all frame_len samples have been consumed, go to OUT and assert m_valid. Otherwise window_base += NI, lane_cnt=0, and go to FILL.
- OUT:
  - m_valid=1; m_result and m_index are held stable until m_valid&m_ready.
  - On that handshake, go to IDLE and m_valid=0.
  - m_result and m_index keep their last value after the handshake.
- Latency: the last sample is accepted at edge t, REDUCE occupies cycle t+1, and m_valid is high from cycle t+2.
- Throughput: NI samples per NI+1 cycles.
- The comparison tree is purely combinational from the window buffer; there are no pipeline registers inside the tree.
- Count arithmetic is modulo 2^CNTW. frame_len <= 2^CNTW-1 is guaranteed by the source.

Test Plan:
- Unsigned min: W=5, NI=7, frame_len=10, samples 12,7,25,7,3,19,3,8,31,3 → m_result=3, m_index=4. The ties at 6 (same window) and 9 (later window) are rejected.
- Signed vs unsigned max: frame_len=3, samples 5'b01111, 5'b10000, 5'b00001.
  - us_sel=1 → m_result=5'b01111, m_index=0.
  - Repeat with us_sel=0 → m_result=5'b10000, m_index=1.
- Partial-window padding: signed min, frame_len=8, samples 0,0,0,0,0,0,0,5'b10000 → m_result=5'b10000, m_index=7.
  - Also frame_len=1 with sample 9 → m_result=9, m_index=0.
- Exact window with stalls and latency: frame_len=7, s_valid toggled every other cycle, max unsigned, samples 1..7.
  - Expect s_ready low only in the REDUCE cycle.
  - Expect m_valid exactly 2 cycles after the last accept, with m_result=7, m_index=6.
- Output backpressure: hold m_ready=0 for 5 cycles; pulse start (frame_len=4) during OUT.
  - m_valid, m_result and m_index stay stable; start is ignored; busy stays 1.
  - After m_ready=1, the next start is accepted.
- Reset and zero length: assert rst after 4 samples of a 10-sample frame → all outputs 0, state IDLE, no m_valid.
  - start with frame_len=0 → busy stays 0.
  - A new 3-sample frame then completes correctly.
